// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first, through a
// DIGIT-long full-adder ripple chain with a registered inter-digit carry.

module serial_addsub_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_addsub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] areg, breg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             a_msb, b_msb;
  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   c;
  logic [WIDTH-1:0] res_nxt;
  logic             last;

  assign c[0] = carry;
  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    serial_addsub_fa u_fa (
      .a (areg[i]),
      .b (breg[i]),
      .ci(c[i]),
      .s (dsum[i]),
      .co(c[i+1])
    );
  end

  // New digit enters at the top; the concat form also covers DIGIT == WIDTH.
  assign res_nxt = WIDTH'({dsum, result} >> DIGIT);
  assign last    = (cnt == CW'(N - 1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      areg   <= '0;
      breg   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          areg  <= a;
          breg  <= sub ? ~b : b;
          carry <= sub;
          cnt   <= '0;
          a_msb <= a[WIDTH-1];
          b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
        end
        RUN: begin
          areg   <= areg >> DIGIT;
          breg   <= breg >> DIGIT;
          carry  <= c[DIGIT];
          cnt    <= cnt + CW'(1);
          result <= res_nxt;
          // Flags only move on the final digit so they stay stable through RUN.
          if (last) begin
            cout <= c[DIGIT];
            zero <= ~|res_nxt;
            ovf  <= (a_msb == b_msb) && (res_nxt[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three configurations (32/4, 8/1, 8/8) checked against an
// arithmetic reference model of a +/- b with carry and signed overflow.

module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st32 = 0, sub32 = 0, busy32, done32, cout32, ovf32, zero32;
  logic [31:0] a32 = 0, b32 = 0, res32;
  logic        st8 = 0, sub8 = 0, busy8, done8, cout8, ovf8, zero8;
  logic [7:0]  a8 = 0, b8 = 0, res8;
  logic        stf = 0, subf = 0, busyf, donef, coutf, ovff, zerof;
  logic [7:0]  af = 0, bf = 0, resf;

  int checks = 0;
  int errors = 0;

  serial_addsub #(.WIDTH(32), .DIGIT(4)) u32 (
    .clk(clk), .rst(rst), .start(st32), .sub(sub32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32), .cout(cout32), .ovf(ovf32), .zero(zero32));
  serial_addsub #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst), .start(st8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8), .zero(zero8));
  serial_addsub #(.WIDTH(8), .DIGIT(8)) u8f (
    .clk(clk), .rst(rst), .start(stf), .sub(subf), .a(af), .b(bf),
    .busy(busyf), .done(donef), .result(resf), .cout(coutf), .ovf(ovff), .zero(zerof));

  // Reference: plain integer arithmetic on w-bit unsigned and signed views.
  function automatic void model(input int w, input longint ua, input longint ub, input bit s,
                                output longint r, output bit co, output bit ov);
    longint m, sa, sb, sr;
    m  = longint'(1) << w;
    r  = s ? ua - ub : ua + ub;
    co = s ? (ua >= ub) : (r >= m);
    r  = ((r % m) + m) % m;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    sr = s ? sa - sb : sa + sb;
    ov = (sr > m / 2 - 1) || (sr < -(m / 2));
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; st32 = 1; st8 = 1; stf = 1;
    step(); step();
    checks++; if ({busy32, done32, cout32, ovf32, zero32, res32} !== '0) begin errors++;
      $display("FAIL reset32 got busy=%b done=%b res=%h c=%b v=%b z=%b want all 0", busy32, done32, res32, cout32, ovf32, zero32); end
    checks++; if ({busy8, done8, cout8, ovf8, zero8, res8} !== '0) begin errors++;
      $display("FAIL reset8 got busy=%b done=%b res=%h c=%b v=%b z=%b want all 0", busy8, done8, res8, cout8, ovf8, zero8); end
    checks++; if ({busyf, donef, coutf, ovff, zerof, resf} !== '0) begin errors++;
      $display("FAIL resetf got busy=%b done=%b res=%h c=%b v=%b z=%b want all 0", busyf, donef, resf, coutf, ovff, zerof); end
    st32 = 0; st8 = 0; stf = 0; rst = 0;
    step();
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input bit s, input string nm);
    longint r; bit co, ov; logic pc, po, pz;
    model(32, a, b, s, r, co, ov);
    pc = cout32; po = ovf32; pz = zero32;
    a32 = a; b32 = b; sub32 = s; st32 = 1;
    step();
    st32 = 0; a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom);
    for (int k = 1; k <= 8; k++) begin
      checks++; if ({busy32, done32, cout32, ovf32, zero32} !== {2'b10, pc, po, pz}) begin errors++;
        $display("FAIL %s_run c%0d got busy=%b done=%b flags=%b%b%b want 1 0 %b%b%b", nm, k, busy32, done32, cout32, ovf32, zero32, pc, po, pz); end
      step();
    end
    checks++; if ({busy32, done32} !== 2'b01) begin errors++;
      $display("FAIL %s_done got busy=%b done=%b want 0 1", nm, busy32, done32); end
    checks++; if (res32 !== 32'(r)) begin errors++;
      $display("FAIL %s_result got %h want %h", nm, res32, 32'(r)); end
    checks++; if ({cout32, ovf32, zero32} !== {co, ov, (r == 0)}) begin errors++;
      $display("FAIL %s_flags got c=%b v=%b z=%b want c=%b v=%b z=%b", nm, cout32, ovf32, zero32, co, ov, r == 0); end
    step();
    checks++; if ({busy32, done32} !== 2'b00 || res32 !== 32'(r)) begin errors++;
      $display("FAIL %s_hold got busy=%b done=%b res=%h want 0 0 %h", nm, busy32, done32, res32, 32'(r)); end
  endtask

  task automatic test_add_sub();
    op32(32'hFFFFFFFF, 32'h1, 0, "wrap");
    op32(32'd5, 32'd7, 1, "sub_neg");
    op32(32'd7, 32'd5, 1, "sub_pos");
    op32(32'h7FFFFFFF, 32'h1, 0, "ovf_add");
    op32(32'h80000000, 32'h1, 1, "ovf_sub");
    for (int i = 0; i < 6; i++) op32($urandom, $urandom, 1'($urandom), "rand32");
  endtask

  task automatic test_ignore_start();
    a32 = 32'h12345678; b32 = 32'h11111111; sub32 = 0; st32 = 1;
    step();
    st32 = 0;
    step(); step();
    a32 = 32'hDEADBEEF; b32 = 32'h0BADF00D; sub32 = 1; st32 = 1;
    step();
    st32 = 0;
    for (int k = 4; k <= 8; k++) step();
    checks++; if (done32 !== 1'b1 || res32 !== 32'h23456789) begin errors++;
      $display("FAIL ignore_start got done=%b res=%h want 1 23456789", done32, res32); end
    step(); step();
    checks++; if ({busy32, done32} !== 2'b00) begin errors++;
      $display("FAIL ignore_noqueue got busy=%b done=%b want 0 0", busy32, done32); end
  endtask

  task automatic test_rst_mid();
    int seen;
    a32 = 32'h0F0F0F0F; b32 = 32'h01010101; sub32 = 0; st32 = 1;
    step();
    st32 = 0;
    step(); step(); step();
    rst = 1;
    step();
    rst = 0;
    checks++; if ({busy32, done32, cout32, ovf32, zero32, res32} !== '0) begin errors++;
      $display("FAIL rst_mid got busy=%b done=%b res=%h c=%b v=%b z=%b want all 0", busy32, done32, res32, cout32, ovf32, zero32); end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (done32 === 1'b1 || busy32 === 1'b1) seen++;
      step();
    end
    checks++; if (seen != 0) begin errors++;
      $display("FAIL rst_mid_nodone got %0d busy/done cycles want 0", seen); end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit s);
    longint r; bit co, ov;
    model(8, a, b, s, r, co, ov);
    a8 = a; b8 = b; sub8 = s; st8 = 1;
    step();
    st8 = 0;
    for (int k = 1; k <= 8; k++) begin
      checks++; if ({busy8, done8} !== 2'b10) begin errors++;
        $display("FAIL d1_run c%0d got busy=%b done=%b want 1 0", k, busy8, done8); end
      step();
    end
    checks++; if ({busy8, done8, res8, cout8, ovf8, zero8} !== {2'b01, 8'(r), co, ov, r == 0}) begin errors++;
      $display("FAIL d1_done got done=%b res=%h c=%b v=%b z=%b want 1 %h %b %b %b", done8, res8, cout8, ovf8, zero8, 8'(r), co, ov, r == 0); end
    step();
  endtask

  task automatic opf(input logic [7:0] a, input logic [7:0] b, input bit s);
    longint r; bit co, ov;
    model(8, a, b, s, r, co, ov);
    af = a; bf = b; subf = s; stf = 1;
    step();
    stf = 0;
    checks++; if ({busyf, donef} !== 2'b10) begin errors++;
      $display("FAIL dfull_run got busy=%b done=%b want 1 0", busyf, donef); end
    step();
    checks++; if ({busyf, donef, resf, coutf, ovff, zerof} !== {2'b01, 8'(r), co, ov, r == 0}) begin errors++;
      $display("FAIL dfull_done got done=%b res=%h c=%b v=%b z=%b want 1 %h %b %b %b", donef, resf, coutf, ovff, zerof, 8'(r), co, ov, r == 0); end
    step();
  endtask

  task automatic test_digit1();
    op8(8'h80, 8'h01, 1);
    op8(8'h00, 8'h00, 0);
    for (int i = 0; i < 10; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic test_digit_full();
    opf(8'h80, 8'h01, 1);
    opf(8'h7F, 8'h01, 0);
    for (int i = 0; i < 10; i++) opf(8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic test_back_to_back();
    longint r; bit co, ov;
    int bad;
    bad = 0;
    st32 = 1;
    for (int i = 0; i < 1000; i++) begin
      a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom);
      model(32, a32, b32, sub32, r, co, ov);
      step();
      for (int k = 1; k <= 8; k++) begin
        if (done32 !== 1'b0) bad++;
        a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom);
        step();
      end
      checks++; if ({done32, res32, cout32, ovf32, zero32} !== {1'b1, 32'(r), co, ov, r == 0}) begin errors++;
        $display("FAIL b2b_%0d got done=%b res=%h c=%b v=%b z=%b want 1 %h %b %b %b", i, done32, res32, cout32, ovf32, zero32, 32'(r), co, ov, r == 0); end
      step();
      if (done32 !== 1'b0 || busy32 !== 1'b0) bad++;
    end
    st32 = 0;
    checks++; if (bad != 0) begin errors++;
      $display("FAIL b2b_period got %0d off-period done/busy cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_ignore_start();
    test_rst_mid();
    test_digit1();
    test_digit_full();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
